// File: rtl/cia_timer_gen_pkg.sv
// Shared types and constants for the generalised CIA interval timer.
package cia;

    typedef enum logic [1:0] {
        TSRC_PHI2     = 2'd0,
        TSRC_CNT      = 2'd1,
        TSRC_CASC     = 2'd2,
        TSRC_CASC_CNT = 2'd3
    } tsrc_t;

    typedef struct packed {
        logic  start;
        logic  runmode;
        logic  outmode;
        logic  force_load;
        tsrc_t src;
    } timer_ctrl_t;

    localparam int TIMER_DELAY_6526 = 2;

endpackage

// File: rtl/cia_timer_gen_pipe.sv
// Tick-enabled delay line between count qualification and the effective decrement.
module cia_timer_pipe #(
    parameter int DELAY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic flush,
    input  logic din,
    output logic dout
);

    generate
        if (DELAY == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [DELAY-1:0] stages;

            // NOTE: state registers use <= so every stage samples the pre-edge value of its neighbour.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stages <= '0;
                end else if (en) begin
                    stages <= flush ? '0 : ((stages << 1) | DELAY'(din));
                end
            end

            assign dout = stages[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/cia_timer_gen.sv
// One CIA-style interval timer: byte-writable latch, down-counter, selectable source,
// one-shot/continuous run and pulse/toggle PB output. Instances chain via casc_i/underflow_o.
module cia_timer_gen
    import cia::*;
#(
    parameter int WIDTH = 16,
    parameter int DELAY = TIMER_DELAY_6526,
    localparam int BYTES = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [BYTES-1:0] latch_we,
    input  logic [WIDTH-1:0] latch_wdata,
    input  logic             start,
    input  logic             runmode,
    input  logic             outmode,
    input  logic             force_load,
    input  logic [1:0]       src,
    input  logic             cnt_i,
    input  logic             casc_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] latch_o,
    output logic             underflow_o,
    output logic             pb_o,
    output logic             start_clr_o
);

    timer_ctrl_t      ctrl;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] latch_q;
    logic [WIDTH-1:0] latch_next;
    logic             cnt_prev;
    logic             start_prev;
    logic             toggle;
    logic             q;
    logic             d;
    logic             uf_now;
    logic             pipe_flush;

    assign ctrl = '{start: start, runmode: runmode, outmode: outmode,
                    force_load: force_load, src: tsrc_t'(src)};

    // NOTE: each always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        latch_next = latch_q;
        for (int i = 0; i < BYTES; i++) begin
            if (latch_we[i]) latch_next[8*i +: 8] = latch_wdata[8*i +: 8];
        end
    end

    always_comb begin
        q = 1'b0;
        case (ctrl.src)
            TSRC_PHI2:     q = ctrl.start;
            TSRC_CNT:      q = ctrl.start & cnt_i & ~cnt_prev;
            TSRC_CASC:     q = ctrl.start & casc_i;
            TSRC_CASC_CNT: q = ctrl.start & casc_i & cnt_i;
            default:       q = 1'b0;
        endcase
    end

    cia_timer_pipe #(.DELAY(DELAY)) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .en    (tick),
        .flush (pipe_flush),
        .din   (q),
        .dout  (d)
    );

    assign uf_now     = d & (count_q == '0) & ~ctrl.force_load;
    assign pipe_flush = ctrl.force_load | (uf_now & ctrl.runmode);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '1;
            latch_q     <= '1;
            cnt_prev    <= 1'b0;
            start_prev  <= 1'b0;
            toggle      <= 1'b0;
            underflow_o <= 1'b0;
            start_clr_o <= 1'b0;
        end else begin
            latch_q <= latch_next;
            // Reloads take latch_q, i.e. the value before any write landing on the same edge.
            if (tick && ctrl.force_load) begin
                count_q <= latch_q;
            end else if (tick && d) begin
                count_q <= (count_q == '0) ? latch_q : count_q - WIDTH'(1);
            end else if (latch_we[BYTES-1] && !ctrl.start) begin
                count_q <= latch_next;
            end

            if (tick) begin
                cnt_prev    <= cnt_i;
                start_prev  <= ctrl.start;
                underflow_o <= uf_now;
                start_clr_o <= uf_now & ctrl.runmode;
                if (ctrl.start && !start_prev) toggle <= 1'b1;
                else if (uf_now)               toggle <= ~toggle;
            end
        end
    end

    assign count_o = count_q;
    assign latch_o = latch_q;
    assign pb_o    = ctrl.outmode ? toggle : underflow_o;

endmodule
